// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types, including the instruction cache frame, tag and FSM state types.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);

    typedef logic [31-ICACHE_IDX_W-2:0] icache_tag_t;

    typedef struct packed {
        logic        valid;
        icache_tag_t tag;
        word_t       data;
    } icache_frame_t;

    typedef enum logic {IDLE, FETCH} icache_state_t;

endpackage

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-frame instruction cache with a blocking miss FSM.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t    state_q, state_d;
    word_t            miss_addr_q, miss_addr_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [SETS];
    word_t            data_q [SETS];
    logic [IDX_W-1:0] idx, midx;
    logic [TAG_W-1:0] tag;
    logic             fill;
    logic             unused_offset;

    assign idx           = imemaddr[IDX_W+1:2];
    assign tag           = imemaddr[31:IDX_W+2];
    assign midx          = miss_addr_q[IDX_W+1:2];
    assign unused_offset = ^imemaddr[1:0];

    assign ihit     = imemREN && (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);
    assign imemload = ihit ? data_q[idx] : '0;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        fill        = 1'b0;
        iREN        = 1'b0;
        iaddr       = '0;
        case (state_q)
            IDLE: begin
                if (imemREN && !ihit) begin
                    state_d     = FETCH;
                    miss_addr_d = imemaddr;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                // The fill always completes, whatever the datapath does meanwhile.
                if (!iwait) begin
                    fill          = 1'b1;
                    valid_d[midx] = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data need no reset: valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[midx]  <= miss_addr_q[31:IDX_W+2];
            data_q[midx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q + {31'b0, ihit};
        miss_count_d = miss_count_q + {31'b0, (state_q == IDLE) && (state_d == FETCH)};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache: the responder on the instruction half of the datapath–cache interface.
- Accepts the datapath's instruction fetch requests (imemREN/imemaddr) and returns ihit/imemload.
- On a miss, issues word reads to the memory controller (iREN/iaddr, waits on iwait, captures iload).
- Sits between datapath and memory controller; the data path (dmem*) is handled by a separate block.

Parameters:
- SETS, 16, number of one-word frames; power of 2, ≥2.
- IDX_W, $clog2(SETS), index width (derived, not overridden).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  fetch byte address, word aligned.
- ihit  output  1  fetch satisfied this cycle.
- imemload  output  32  instruction word, valid when ihit=1.
- iREN  output  1  read request to memory controller.
- iaddr  output  32  memory read address.
- iwait  input  1  memory busy; iwait=0 while iREN=1 means iload is valid this cycle.
- iload  input  32  memory read data.
- hit_count  output  32  hit counter (see Optional Feature).
- miss_count  output  32  miss counter (see Optional Feature).

Behaviour:
- Address split: byte offset [1:0] ignored; index = imemaddr[IDX_W+1:2]; tag = imemaddr[31:IDX_W+2].
- Frame contents: valid bit, tag, 32-bit data.
- Hit logic is combinational: ihit = imemREN & (state==IDLE) & valid[idx] & tag match. imemload = data[idx] when ihit=1, else 0.
- FSM states:
  - IDLE: on imemREN with no hit, latch imemaddr into miss_addr and go to FETCH. Otherwise stay.
  - FETCH: iREN=1, iaddr=miss_addr. When iwait=0, write data=iload, tag and valid=1 into frame idx(miss_addr), then go to IDLE. ihit stays 0 throughout FETCH (no forwarding).
- Latency:
  - Hit: same cycle (0 wait).
  - Miss: 1 (detect) + N memory cycles + 1 (hit from array) cycles.
- The fill completes even if imemREN drops or imemaddr changes mid-FETCH; the fill is never aborted. The next IDLE cycle evaluates the new request.
- Conflict miss (same index, different tag): the frame is overwritten. No associativity.
- iREN=0 and iaddr=0 in IDLE.
- Reset, asynchronous, including mid-FETCH:
  - All valid bits cleared; state=IDLE; miss_addr=0.
  - Outputs go to ihit=0, imemload=0, iREN=0, iaddr=0; counters=0.
  - An in-flight memory read is abandoned.
- Tag and data arrays need no reset; only the valid bits are reset.
- Never writes memory. Self-modifying code is unsupported.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - hit_count increments on each cycle ihit=1.
  - miss_count increments on each IDLE→FETCH transition.
  - Both 32-bit, wrap at 2^32-1 → 0, reset to 0.
- Undefined: both outputs tied to 0 and no counter flops are synthesized. Ports exist in both builds.

Decomposition:
- cpu_types_pkg: add ICACHE_SETS constant, icache_tag_t, and icache_frame_t (packed struct: valid, tag, data word_t).
- cpu_types_pkg: add icache_state_t enum {IDLE, FETCH}.
- Reuse word_t.
- No sub-module: the array and FSM fit cleanly in one module.
- Integration wrapper maps ports to datapath_cache_if.cache and cache_control_if modports.

Test Plan:
- Cold miss: reset, imemREN=1, imemaddr=0x0000_0004; memory holds iwait=1 for 2 cycles then iload=0x2001_0005 → iREN=1 with iaddr=0x4 for 3 cycles; ihit=1 and imemload=0x2001_0005 on the following cycle; miss_count=1.
- Warm hit: repeat fetch of 0x4 → ihit=1 same cycle, iREN stays 0; hit_count increments every cycle.
- Conflict: fetch 0x4, then 0x44 (same index 1, SETS=16) → second access misses and refills. Refetch of 0x4 misses again.
- Abandoned request: start a miss on 0x8, drop imemREN after 1 cycle → FETCH completes. A later fetch of 0x8 hits with no iREN.
- Reset mid-FETCH: assert nRST=0 while iREN=1 → iREN=0 and ihit=0 immediately. After release, a previously cached 0x4 misses.
- Stats off: compile without ICACHE_STATS_EN, run the cold-miss test → hit_count=miss_count=0 throughout.
